// File: rtl/multi_timer.sv
// Multi-channel down-counting timer: shared prescaler tick, per-channel period load,
// periodic or one-shot expiry strobes, enable gating and registered count readback.
module multi_timer #(
   parameter int NCH      = 4,
   parameter int CNT_W    = 21,
   parameter int TICK_DIV = 12,
   localparam int SEL_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick_sync,
   input  logic [NCH-1:0]   ld,
   input  logic [CNT_W-1:0] ld_val,
   input  logic             ld_mode,
   input  logic [NCH-1:0]   en,
   input  logic [NCH-1:0]   clr,
   input  logic [SEL_W-1:0] rd_sel,
   output logic [NCH-1:0]   pulse,
   output logic [NCH-1:0]   running,
   output logic [NCH-1:0]   done,
   output logic [CNT_W-1:0] rd_count
);

   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   logic [PRE_W-1:0] pre_r;
   logic             tick_s;
   logic [CNT_W-1:0] period_r [NCH];
   logic [CNT_W-1:0] count_r  [NCH];
   logic [NCH-1:0]   mode_r;
   state_t           state_r  [NCH];
   logic [NCH-1:0]   pulse_r;
   logic [CNT_W-1:0] rd_count_r;
   logic [CNT_W-1:0] rd_mux_s;

   // With TICK_DIV=1 the prescaler is pinned at 0 and the tick is permanently high.
   assign tick_s = (pre_r == PRE_MAX);

   // Free-running prescaler, restarted by tick_sync or on wrap.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_r <= '0;
      end else if (tick_sync || tick_s) begin
         pre_r <= '0;
      end else begin
         pre_r <= pre_r + PRE_W'(1);
      end
   end

   // Per-channel state machine: clr beats ld beats tick decrement.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NCH; i++) begin
            period_r[i] <= '0;
            count_r[i]  <= '0;
            state_r[i]  <= ST_IDLE;
         end
         mode_r  <= '0;
         pulse_r <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            pulse_r[i] <= 1'b0;
            if (clr[i]) begin
               count_r[i] <= '0;
               state_r[i] <= ST_IDLE;
            end else if (ld[i]) begin
               period_r[i] <= ld_val;
               count_r[i]  <= ld_val;
               mode_r[i]   <= ld_mode;
               state_r[i]  <= (ld_val != '0) ? ST_RUN : ST_IDLE;
            end else begin
               case (state_r[i])
                  ST_RUN: begin
                     if (tick_s && en[i]) begin
                        if (count_r[i] > CNT_W'(1)) begin
                           count_r[i] <= count_r[i] - CNT_W'(1);
                        end else begin
                           pulse_r[i] <= 1'b1;
                           if (mode_r[i]) begin
                              count_r[i] <= '0;
                              state_r[i] <= ST_DONE;
                           end else begin
                              count_r[i] <= period_r[i];
                           end
                        end
                     end
                  end
                  ST_IDLE: begin
                     count_r[i] <= count_r[i];
                  end
                  ST_DONE: begin
                     count_r[i] <= count_r[i];
                  end
                  default: begin
                     state_r[i] <= ST_IDLE;
                  end
               endcase
            end
         end
      end
   end

   // Readback mux; selects beyond NCH fall through to zero.
   always_comb begin
      rd_mux_s = '0;
      for (int i = 0; i < NCH; i++) begin
         rd_mux_s = rd_mux_s | ((rd_sel == SEL_W'(i)) ? count_r[i] : '0);
      end
   end

   // Registered readback.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_count_r <= '0;
      end else begin
         rd_count_r <= rd_mux_s;
      end
   end

   // Status flags decode straight from the state registers.
   always_comb begin
      running = '0;
      done    = '0;
      for (int i = 0; i < NCH; i++) begin
         running[i] = (state_r[i] == ST_RUN);
         done[i]    = (state_r[i] == ST_DONE);
      end
   end

   assign pulse    = pulse_r;
   assign rd_count = rd_count_r;

endmodule
